// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the pipelined MIPS core.
// Owns the fetch PC, reads the combinational instruction ROM and buffers
// {pc, instr} pairs in a small circular queue toward decode. Redirects,
// exceptions and interrupts flush the queue and steer fetch; the kernel
// bit (pc[31]) of the instruction at the head masks interrupts.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INT_PC   = 32'h8000_0004,
    parameter logic [31:0] EXP_PC   = 32'h8000_0008,
    parameter int          QDEPTH   = 4,
    parameter int          QPTR_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [30:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    input  logic        irq,
    output logic        trap_valid,
    output logic        trap_cause,
    output logic [31:0] trap_epc
);

    // Sequential PC step: the kernel bit is preserved and only the low
    // 31 bits wrap, so fetch never silently crosses between user and
    // kernel space.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    logic [31:0]     fetch_pc;
    logic [31:0]     fetch_pc_next;

    logic [31:0]     q_pc    [QDEPTH];
    logic [31:0]     q_instr [QDEPTH];
    logic [QPTR_W-1:0] head_ptr;
    logic [QPTR_W-1:0] tail_ptr;
    logic [QPTR_W:0]   count;

    logic            q_full;
    logic            flush_redirect;
    logic            flush_exc;
    logic            flush_irq;
    logic            flush;
    logic            pop;
    logic            push;

    // Head of the queue is presented straight from storage (no bypass).
    always_comb begin
        out_valid    = (count != '0);
        out_pc       = q_pc[head_ptr];
        out_instr    = q_instr[head_ptr];
        out_pc_plus4 = pc_plus4(q_pc[head_ptr]);
        imem_addr    = fetch_pc[30:0];
    end

    // Flush arbitration: redirect beats exception beats interrupt; a
    // lower-priority event in the same cycle is dropped, not remembered.
    always_comb begin
        // QDEPTH is a power of two, so the count MSB alone marks full.
        q_full         = count[QPTR_W];
        flush_redirect = redirect_valid;
        flush_exc      = !redirect_valid && exc && out_valid;
        flush_irq      = !redirect_valid && !(exc && out_valid)
                         && irq && out_valid && !out_pc[31];
        flush          = flush_redirect || flush_exc || flush_irq;
        pop            = out_valid && out_ready && !flush;
        push           = !flush && (!q_full || pop);
    end

    // Next fetch PC: flush target, sequential step on push, else hold.
    always_comb begin
        fetch_pc_next = fetch_pc;
        if (flush_redirect) begin
            fetch_pc_next = redirect_pc;
        end else if (flush_exc) begin
            fetch_pc_next = EXP_PC;
        end else if (flush_irq) begin
            fetch_pc_next = INT_PC;
        end else if (push) begin
            fetch_pc_next = pc_plus4(fetch_pc);
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_next;
        end
    end

    // Queue pointers and occupancy; a flush empties the queue in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (pop) begin
                head_ptr <= head_ptr + QPTR_W'(1);
            end
            if (push) begin
                tail_ptr <= tail_ptr + QPTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (QPTR_W + 1)'(1);
                2'b01:   count <= count - (QPTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: the fetched word is written at the tail alongside
    // the PC it came from.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (push) begin
            q_pc[tail_ptr]    <= fetch_pc;
            q_instr[tail_ptr] <= imem_data;
        end
    end

    // Trap report: one-cycle pulse; cause and EPC stay until the next trap.
    // An exception returns past the faulting word, an interrupt re-executes
    // the head because it was never consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_valid <= 1'b0;
            trap_cause <= 1'b0;
            trap_epc   <= '0;
        end else begin
            trap_valid <= flush_exc || flush_irq;
            if (flush_exc) begin
                trap_cause <= 1'b0;
                trap_epc   <= out_pc_plus4;
            end else if (flush_irq) begin
                trap_cause <= 1'b1;
                trap_epc   <= out_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a decoupled scoreboard. The
// stimulus pushes the PCs it expects decode to accept, and the traps it
// expects, into queues; a monitor pops and compares whenever the DUT
// hands over a head or pulses trap_valid.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INT_PC   = 32'h8000_0004;
    localparam logic [31:0] EXP_PC   = 32'h8000_0008;
    localparam logic [31:0] ROM_KEY  = 32'h5A00_0000;

    logic        clk;
    logic        reset;
    logic [30:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc;
    logic        irq;
    logic        trap_valid;
    logic        trap_cause;
    logic [31:0] trap_epc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [32:0] trap_q[$];

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .INT_PC  (INT_PC),
        .EXP_PC  (EXP_PC),
        .QDEPTH  (4),
        .QPTR_W  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc           (exc),
        .irq           (irq),
        .trap_valid    (trap_valid),
        .trap_cause    (trap_cause),
        .trap_epc      (trap_epc)
    );

    function automatic logic [31:0] rom_word(input logic [30:0] a);
        return {1'b0, a} ^ ROM_KEY;
    endfunction

    function automatic logic [31:0] plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    assign imem_data = rom_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, after the stimulus has settled its inputs.
    always begin
        logic [31:0] e;
        logic [32:0] t;
        @(negedge clk);
        #2;
        if (reset && out_valid && out_ready
            && !(redirect_valid || exc || (irq && !out_pc[31]))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop_pc", out_pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("head_pc", out_pc, e);
                check("head_instr", out_instr, rom_word(e[30:0]));
                check("head_pc_plus4", out_pc_plus4, plus4(e));
            end
        end
        if (reset && trap_valid) begin
            if (trap_q.size() == 0) begin
                check("unexpected_trap_epc", trap_epc, 32'hxxxx_xxxx);
            end else begin
                t = trap_q.pop_front();
                check("trap_cause", {31'd0, trap_cause}, {31'd0, t[32]});
                check("trap_epc", trap_epc, t[31:0]);
            end
        end
    end

    // Expect start..stop (exclusive) to be accepted, then wait at a negedge
    // until stop is the head. Leaves the caller at that negedge.
    task automatic stream_to(input logic [31:0] start, input logic [31:0] stop,
                             output int cycles);
        logic [31:0] pc;
        pc = start;
        cycles = 0;
        while (pc != stop) begin
            exp_q.push_back(pc);
            pc = plus4(pc);
        end
        while (!(out_valid && out_pc == stop)) begin
            @(negedge clk);
            cycles++;
            if (cycles > 64) begin
                check("wait_head_timeout", out_pc, stop);
                break;
            end
        end
    endtask

    // Drive a flush event for one cycle, then check the one-cycle bubble
    // and that the target becomes the head.
    task automatic fire(input string name, input logic rv, input logic [31:0] rpc,
                        input logic e, input logic i, input logic [31:0] target,
                        input logic exp_trap, input logic cause, input logic [31:0] epc);
        if (exp_trap) trap_q.push_back({cause, epc});
        redirect_valid = rv;
        redirect_pc    = rpc;
        exc            = e;
        irq            = i;
        @(negedge clk);
        redirect_valid = 1'b0;
        exc            = 1'b0;
        irq            = 1'b0;
        check({name, "_bubble"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_target"}, out_pc, target);
    endtask

    initial begin
        int cyc;
        reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        exc            = 1'b0;
        irq            = 1'b0;

        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("rst_trap_cause", {31'd0, trap_cause}, 32'd0);
        check("rst_trap_epc", trap_epc, 32'd0);
        check("rst_imem_addr", {1'b0, imem_addr}, RESET_PC);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first_cycle_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("second_cycle_valid", {31'd0, out_valid}, 32'd1);
        check("second_cycle_pc", out_pc, 32'd0);
        repeat (9) @(negedge clk);
        check("stall_imem_addr", {1'b0, imem_addr}, 32'h10);
        check("stall_head_pc", out_pc, 32'd0);

        // Release: one head per cycle, no gaps.
        out_ready = 1'b1;
        stream_to(32'h0, 32'h28, cyc);
        check("stream_cycles", cyc, 32'd10);

        // Fill the queue, then redirect while full.
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("full_imem_addr", {1'b0, imem_addr}, 32'h38);
        fire("redir_full", 1'b1, 32'h100, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        stream_to(32'h100, 32'h10C, cyc);
        fire("redir_30", 1'b1, 32'h30, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0, 32'h0);

        // Interrupt taken from user space; head is not consumed.
        stream_to(32'h30, 32'h40, cyc);
        fire("irq_user", 1'b0, 32'h0, 1'b0, 1'b1, INT_PC, 1'b1, 1'b1, 32'h40);

        // Interrupt held high while heads are in kernel space: masked.
        irq = 1'b1;
        stream_to(INT_PC, 32'h8000_0014, cyc);
        irq = 1'b0;
        fire("redir_18", 1'b1, 32'h18, 1'b0, 1'b0, 32'h18, 1'b0, 1'b0, 32'h0);

        // Exception beats interrupt in the same cycle.
        stream_to(32'h18, 32'h20, cyc);
        fire("exc_irq", 1'b0, 32'h0, 1'b1, 1'b1, EXP_PC, 1'b1, 1'b0, 32'h24);

        // Redirect beats exception; then low-31-bit wrap in user space.
        stream_to(EXP_PC, 32'h8000_0010, cyc);
        fire("redir_exc", 1'b1, 32'h7FFF_FFF8, 1'b1, 1'b0, 32'h7FFF_FFF8, 1'b0, 1'b0, 32'h0);
        stream_to(32'h7FFF_FFF8, 32'h8, cyc);

        // Wrap in kernel space keeps bit 31.
        fire("redir_kwrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        stream_to(32'hFFFF_FFFC, 32'h8000_0004, cyc);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_imem_addr", {1'b0, imem_addr}, RESET_PC);
        check("midrst_trap_cause", {31'd0, trap_cause}, 32'd0);
        check("midrst_trap_epc", trap_epc, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst_valid", {31'd0, out_valid}, 32'd1);
        check("postrst_pc", out_pc, RESET_PC);
        @(negedge clk);

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("trap_q_drained", trap_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
